// File: rtl/sd_arbiter.sv
// sd_arbiter: round-robin sharing of the MiST SD block port among up to four disk clients.
module sd_arbiter #(
    parameter int CLIENTS   = 4,
    parameter int TIMEOUT_W = 24
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [CLIENTS-1:0]     req_rd,
    input  logic [CLIENTS-1:0]     req_wr,
    input  logic [32*CLIENTS-1:0]  req_lba,
    output logic [CLIENTS-1:0]     req_busy,
    output logic [CLIENTS-1:0]     req_done,
    output logic [CLIENTS-1:0]     req_err,
    output logic [8:0]             buff_addr,
    output logic [7:0]             buff_dout,
    output logic [CLIENTS-1:0]     buff_wr,
    input  logic [8*CLIENTS-1:0]   buff_din,
    output logic [1:0]             grant,
    output logic [31:0]            sd_lba,
    output logic                   sd_rd,
    output logic                   sd_wr,
    input  logic                   sd_ack,
    input  logic [8:0]             sd_buff_addr,
    input  logic [7:0]             sd_buff_dout,
    input  logic                   sd_buff_wr,
    output logic [7:0]             sd_buff_din
);
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;
    state_t                 state, state_nx;
    logic [1:0]             last, last_nx, grant_nx, win;
    logic                   found, rd_nx, wr_nx;
    logic [31:0]            lba_nx;
    logic [TIMEOUT_W-1:0]   cnt, cnt_nx;
    logic [CLIENTS-1:0]     pend, err_nx, gsel;

    function automatic logic [1:0] wrap(input int v);
        return 2'(v % CLIENTS);
    endfunction

    assign pend = req_rd | req_wr;
    assign gsel = CLIENTS'(1) << grant;

    // Search starts just after the previous owner so it ends up lowest priority.
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int k = 1; k <= CLIENTS; k++) begin
            if (!found && pend[wrap(int'(last) + k)]) begin
                found = 1'b1;
                win   = wrap(int'(last) + k);
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last;
        lba_nx   = sd_lba;
        rd_nx    = sd_rd;
        wr_nx    = sd_wr;
        cnt_nx   = cnt;
        err_nx   = '0;
        case (state)
            IDLE: if (found) begin
                state_nx = ISSUE;
                grant_nx = win;
                last_nx  = win;
                lba_nx   = req_lba[32*win +: 32];
                rd_nx    = ~req_wr[win];
                wr_nx    = req_wr[win];
                cnt_nx   = '0;
            end
            ISSUE: begin
                cnt_nx = cnt + 1'b1;
                if (sd_ack) begin
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    state_nx = XFER;
                end else if (&cnt_nx) begin
                    rd_nx         = 1'b0;
                    wr_nx         = 1'b0;
                    err_nx[grant] = 1'b1;
                    state_nx      = IDLE;
                end
            end
            XFER:    state_nx = sd_ack ? XFER : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            last    <= 2'(CLIENTS - 1);
            sd_lba  <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            cnt     <= '0;
            req_err <= '0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            last    <= last_nx;
            sd_lba  <= lba_nx;
            sd_rd   <= rd_nx;
            sd_wr   <= wr_nx;
            cnt     <= cnt_nx;
            req_err <= err_nx;
        end
    end

    assign req_busy    = (state == ISSUE || state == XFER) ? gsel : '0;
    assign req_done    = (state == DONE) ? gsel : '0;
    assign buff_wr     = (sd_buff_wr && state == XFER) ? gsel : '0;
    assign buff_addr   = sd_buff_addr;
    assign buff_dout   = sd_buff_dout;
    assign sd_buff_din = buff_din[8*grant +: 8];
endmodule

// File: tb/tb_sd_arbiter.sv
// tb_sd_arbiter: vector table plus hand sequences; grants checked against a queue of expected owners.
module tb_sd_arbiter;
    localparam int N = 4;

    typedef struct {
        logic [1:0]  c;
        logic        rd;
        logic        wr;
        logic [31:0] lba;
    } exp_t;

    typedef struct {
        int          c;
        logic        rd;
        logic        wr;
        logic [31:0] lba;
        logic [7:0]  din;
        int          pulses;
    } vec_t;

    logic           clk_sys = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_rd = '0, req_wr = '0;
    logic [32*N-1:0] req_lba = '0;
    logic [8*N-1:0] buff_din = '0;
    logic [N-1:0]   req_busy, req_done, req_err, buff_wr;
    logic [8:0]     buff_addr;
    logic [7:0]     buff_dout, sd_buff_din;
    logic [1:0]     grant;
    logic [31:0]    sd_lba;
    logic           sd_rd, sd_wr;
    logic           sd_ack = 1'b0;
    logic [8:0]     sd_buff_addr = '0;
    logic [7:0]     sd_buff_dout = '0;
    logic           sd_buff_wr = 1'b0;

    int   n_chk = 0, n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic act_q = 1'b0;
    vec_t vecs[5];

    sd_arbiter #(.CLIENTS(N), .TIMEOUT_W(4)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
        .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
        .buff_addr(buff_addr), .buff_dout(buff_dout), .buff_wr(buff_wr), .buff_din(buff_din),
        .grant(grant), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic request(input int c, input logic rd, input logic wr, input logic [31:0] lba);
        exp_t e;
        req_lba[32*c +: 32] = lba;
        req_rd[c] = rd;
        req_wr[c] = wr;
        e.c = 2'(c);
        e.rd = rd & ~wr;
        e.wr = wr;
        e.lba = lba;
        sb.push_back(e);
    endtask

    // Each new ISSUE (rising sd_rd|sd_wr) must match the oldest expected grant.
    always @(negedge clk_sys) begin
        if ((sd_rd | sd_wr) && !act_q) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_grant: got grant %0d with no expected owner", grant);
            end else begin
                mon_e = sb.pop_front();
                check("sb_grant", 32'(grant), 32'(mon_e.c));
                check("sb_sd_rd", 32'(sd_rd), 32'(mon_e.rd));
                check("sb_sd_wr", 32'(sd_wr), 32'(mon_e.wr));
                check("sb_sd_lba", sd_lba, mon_e.lba);
            end
        end
        act_q = sd_rd | sd_wr;
    end

    task automatic do_reset();
        tick();
        reset = 1'b1;
        req_rd = '0;
        req_wr = '0;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int bad;
        tick();
        buff_din = '0;
        buff_din[8*v.c +: 8] = v.din;
        request(v.c, v.rd, v.wr, v.lba);
        tick();
        check("grant_latency", 32'(sd_rd | sd_wr), 1);
        check("busy_on", 32'(req_busy), 32'(4'(1) << v.c));
        sd_ack = 1'b1;
        tick();
        check("rdwr_fall", 32'({sd_rd, sd_wr}), 0);
        bad = 0;
        for (int p = 0; p < v.pulses; p++) begin
            sd_buff_addr = 9'(p);
            sd_buff_dout = 8'(p * 7);
            sd_buff_wr = 1'b1;
            #1;
            if (buff_wr !== (4'(1) << v.c) || buff_addr !== 9'(p) ||
                buff_dout !== 8'(p * 7) || sd_buff_din !== v.din) bad++;
            tick();
            sd_buff_wr = 1'b0;
            #1;
            if (buff_wr !== '0 || sd_buff_din !== v.din) bad++;
            tick();
        end
        check("buff_route_errors", 32'(bad), 0);
        sd_ack = 1'b0;
        tick();
        check("done_pulse", 32'(req_done), 32'(4'(1) << v.c));
        check("busy_off", 32'(req_busy), 0);
        req_rd[v.c] = 1'b0;
        req_wr[v.c] = 1'b0;
        tick();
        check("done_clear", 32'(req_done), 0);
    endtask

    task automatic serve(input int c);
        int t;
        t = 0;
        while (!req_busy[c] && t < 50) begin
            tick();
            t++;
        end
        check($sformatf("serve_busy%0d", c), 32'(req_busy[c]), 1);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        t = 0;
        while (!req_done[c] && t < 10) begin
            tick();
            t++;
        end
        check($sformatf("serve_done%0d", c), 32'(req_done[c]), 1);
        req_rd[c] = 1'b0;
        req_wr[c] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, bad;
        vecs[0] = '{c: 1, rd: 1'b1, wr: 1'b0, lba: 32'h0000_1234, din: 8'h11, pulses: 512};
        vecs[1] = '{c: 3, rd: 1'b0, wr: 1'b1, lba: 32'hFFFF_FFFF, din: 8'hA5, pulses: 8};
        vecs[2] = '{c: 2, rd: 1'b1, wr: 1'b1, lba: 32'hCAFE_BABE, din: 8'h3C, pulses: 4};
        vecs[3] = '{c: 0, rd: 1'b1, wr: 1'b0, lba: 32'h0000_0000, din: 8'h5A, pulses: 2};
        vecs[4] = '{c: 1, rd: 1'b1, wr: 1'b0, lba: 32'h0000_55AA, din: 8'h77, pulses: 2};

        sd_buff_wr = 1'b1;
        tick();
        tick();
        check("rst_sd_rd", 32'(sd_rd), 0);
        check("rst_sd_wr", 32'(sd_wr), 0);
        check("rst_sd_lba", sd_lba, 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy_done_err", 32'({req_busy, req_done, req_err}), 0);
        check("rst_buff_wr", 32'(buff_wr), 0);
        sd_buff_wr = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) run_txn(vecs[i]);

        // Contention straight after reset: client 0 wins, then 2.
        do_reset();
        tick();
        request(0, 1'b1, 1'b0, 32'h0000_0100);
        request(2, 1'b1, 1'b0, 32'h0000_0200);
        serve(0);
        serve(2);

        // All four held, each dropping for one cycle at done: 0,1,2,3,0.
        do_reset();
        tick();
        for (int c = 0; c < 4; c++) request(c, 1'b1, 1'b0, 32'(c + 16));
        request(0, 1'b1, 1'b0, 32'd16);
        for (int c = 0; c < 4; c++) begin
            serve(c);
            tick();
            req_rd[c] = 1'b1;
        end
        serve(0);
        req_rd = '0;
        tick();
        tick();

        // Timeout on client 0 with client 1 waiting behind it.
        do_reset();
        tick();
        request(0, 1'b1, 1'b0, 32'h0000_0ABC);
        request(1, 1'b1, 1'b0, 32'h0000_0DEF);
        tick();
        check("tmo_granted", 32'(sd_rd), 1);
        t = 0;
        while (!req_err[0] && t < 40) begin
            tick();
            t++;
        end
        check("tmo_latency", 32'(t), 15);
        check("tmo_err_onehot", 32'(req_err), 1);
        check("tmo_sd_rd_low", 32'(sd_rd), 0);
        check("tmo_busy_low", 32'(req_busy), 0);
        req_rd[0] = 1'b0;
        tick();
        check("tmo_next_grant", 32'(sd_rd), 1);
        check("tmo_next_busy", 32'(req_busy), 32'b0010);
        check("tmo_err_clear", 32'(req_err), 0);
        serve(1);
        tick();

        // Reset mid-XFER while the ARM keeps strobing sd_buff_wr.
        tick();
        request(2, 1'b1, 1'b0, 32'h0000_0777);
        tick();
        sd_ack = 1'b1;
        tick();
        sd_buff_wr = 1'b1;
        #1;
        check("xfer_buff_wr", 32'(buff_wr), 32'b0100);
        reset = 1'b1;
        req_rd = '0;
        #1;
        check("rstx_sd_rd_wr", 32'({sd_rd, sd_wr}), 0);
        check("rstx_sd_lba", sd_lba, 0);
        check("rstx_grant", 32'(grant), 0);
        check("rstx_busy", 32'(req_busy), 0);
        check("rstx_buff_wr", 32'(buff_wr), 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 2) reset = 1'b0;
            sd_buff_wr = ~sd_buff_wr;
            #1;
            if (buff_wr !== '0) bad++;
        end
        check("rstx_buff_wr_blocked", 32'(bad), 0);
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        run_txn(vecs[4]);

        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
